// File: rtl/cmv300_pipe_reader_pkg.sv
// cmv300_pipe_reader_pkg: FSM encodings and CMV300 frame geometry shared by the pipe reader.
package cmv300_pipe_reader_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRIG  = 3'd1,
    S_WAIT  = 3'd2,
    S_BURST = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  localparam int CMV_WIDTH       = 648;
  localparam int CMV_HEIGHT      = 488;
  localparam int CMV_PX_PER_WORD = 4;
  localparam int CMV_FRAME_WORDS = CMV_WIDTH * CMV_HEIGHT / CMV_PX_PER_WORD;
endpackage

// File: rtl/cmv300_pipe_reader.sv
// cmv300_pipe_reader: drains the capture FIFO into fixed-size host pipe-out blocks,
// zero-padding the last block of each frame and pacing frames with a sensor trigger.
module cmv300_pipe_reader
  import cmv300_pipe_reader_pkg::*;
#(
  parameter int FRAME_WORDS = CMV_FRAME_WORDS,
  parameter int BLOCK_WORDS = 1024,
  parameter int CNT_W       = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_continuous,
  output logic             o_frame_trigger,
  input  logic [31:0]      i_fifo_data,
  input  logic [CNT_W-1:0] i_fifo_rd_count,
  input  logic             i_fifo_empty,
  output logic             o_fifo_read_en,
  input  logic             i_pipe_read,
  output logic             o_pipe_ready,
  output logic [31:0]      o_pipe_data,
  output logic             o_frame_done,
  output logic [15:0]      o_frame_count,
  output logic             o_underflow,
  output logic             o_spurious
);
  localparam logic [CNT_W-1:0] FRM = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] BLK = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t           state_q;
  logic             start_q, ready_q, ready_d, trig_q, done_q, pad_sel_q, underflow_q, spurious_q;
  logic [CNT_W-1:0] frame_rem_q, frame_rem_d, blk_cnt_q, blk_cnt_d, need;
  logic [15:0]      frame_count_q;
  logic             take, strobe_ok, real_rd, blk_end;
  always_comb begin
    take        = i_pipe_read && state_q == S_WAIT && ready_q;
    strobe_ok   = take || (i_pipe_read && state_q == S_BURST);
    real_rd     = strobe_ok && frame_rem_q != '0;
    frame_rem_d = real_rd ? frame_rem_q - ONE : frame_rem_q;
    blk_end     = strobe_ok && blk_cnt_q == BLK - ONE;
    blk_cnt_d   = blk_end ? '0 : strobe_ok ? blk_cnt_q + ONE : blk_cnt_q;
    need        = frame_rem_q < BLK ? frame_rem_q : BLK;
    ready_d     = state_q == S_WAIT && !take && i_fifo_rd_count >= need;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      ready_q       <= 1'b0;
      trig_q        <= 1'b0;
      done_q        <= 1'b0;
      pad_sel_q     <= 1'b1;
      underflow_q   <= 1'b0;
      spurious_q    <= 1'b0;
      frame_rem_q   <= '0;
      blk_cnt_q     <= '0;
      frame_count_q <= '0;
    end else begin
      start_q     <= i_start;
      ready_q     <= ready_d;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      // anything but a real FIFO read (pad strobe or idle cycle) presents zero data
      pad_sel_q   <= !real_rd;
      blk_cnt_q   <= blk_cnt_d;
      frame_rem_q <= frame_rem_d;
      if (real_rd && i_fifo_empty) underflow_q <= 1'b1;
      if (i_pipe_read && !strobe_ok) spurious_q <= 1'b1;
      case (state_q)
        S_IDLE: if (i_start && !start_q) begin
          state_q <= S_TRIG;
          trig_q  <= 1'b1;
        end
        S_TRIG: begin
          frame_rem_q <= FRM;
          state_q     <= S_WAIT;
        end
        S_WAIT: if (take) state_q <= S_BURST;
        S_BURST: if (blk_end) begin
          state_q <= frame_rem_d == '0 ? S_DONE : S_WAIT;
          done_q  <= frame_rem_d == '0;
        end
        S_DONE: begin
          frame_count_q <= frame_count_q + 16'd1;
          state_q       <= i_continuous ? S_TRIG : S_IDLE;
          trig_q        <= i_continuous;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign o_frame_trigger = trig_q;
  assign o_fifo_read_en  = real_rd;
  assign o_pipe_ready    = ready_q;
  assign o_pipe_data     = pad_sel_q ? 32'd0 : i_fifo_data;
  assign o_frame_done    = done_q;
  assign o_frame_count   = frame_count_q;
  assign o_underflow     = underflow_q;
  assign o_spurious      = spurious_q;
endmodule

// File: tb/tb_cmv300_pipe_reader.sv
// tb_cmv300_pipe_reader: directed scenarios against a small FIFO model with FRAME_WORDS=10, BLOCK_WORDS=4.
module tb_cmv300_pipe_reader;
  import cmv300_pipe_reader_pkg::*;
  localparam int FW = 10;
  localparam int BW = 4;
  localparam int CW = 17;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, cont = 1'b0, pipe_read = 1'b0;
  logic          trig, rd_en, ready, done, under, spur;
  logic [31:0]   fifo_data = 32'd0, pipe_data;
  logic [CW-1:0] rd_count;
  logic          empty;
  logic [15:0]   frame_count;
  logic [31:0]   mem [0:63];
  int            wr_ptr = 0, rd_ptr = 0, force_cnt = -1;
  logic          force_empty = 1'b0;
  int            rd_cnt = 0, trig_cnt = 0, done_cnt = 0;
  int            passed = 0, total = 0;
  logic [31:0]   got [0:15];
  int            gi;
  cmv300_pipe_reader #(.FRAME_WORDS(FW), .BLOCK_WORDS(BW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_continuous(cont),
    .o_frame_trigger(trig), .i_fifo_data(fifo_data), .i_fifo_rd_count(rd_count),
    .i_fifo_empty(empty), .o_fifo_read_en(rd_en), .i_pipe_read(pipe_read),
    .o_pipe_ready(ready), .o_pipe_data(pipe_data), .o_frame_done(done),
    .o_frame_count(frame_count), .o_underflow(under), .o_spurious(spur)
  );
  always #5 clk = ~clk;
  assign rd_count = force_cnt >= 0 ? CW'(force_cnt) : CW'(wr_ptr - rd_ptr);
  assign empty    = force_empty || (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (rd_en && wr_ptr != rd_ptr) begin
      fifo_data <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (trig) trig_cnt <= trig_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic preload(input int first, input int n);
    wr_ptr = rd_ptr;
    for (int i = 0; i < n; i++) mem[(wr_ptr + i) % 64] = 32'(first + i);
    wr_ptr = wr_ptr + n;
  endtask
  task automatic read_block(input string tag);
    for (int k = 0; k < 50 && !ready; k++) tick();
    total++;
    if (ready !== 1'b1) $display("FAIL %s ready: got %b want 1", tag, ready); else passed++;
    pipe_read = 1'b1;
    for (int i = 0; i < BW; i++) begin
      tick();
      got[gi] = pipe_data;
      gi++;
    end
    pipe_read = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if ({trig, ready, done, under, spur, rd_en} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {trig, ready, done, under, spur, rd_en}); else passed++;
    total++;
    if (pipe_data !== 32'd0) $display("FAIL reset_data: got %h want 0", pipe_data); else passed++;
    total++;
    if (frame_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", frame_count); else passed++;
    total++;
    if (dut.state_q !== S_IDLE) $display("FAIL reset_state: got %0d want 0", dut.state_q); else passed++;
  endtask
  task automatic test_frame();
    int rd0, tr0;
    logic [31:0] exp_d;
    rd0 = rd_cnt;
    tr0 = trig_cnt;
    preload(1, FW);
    start = 1'b1;
    tick();
    total++;
    if (trig !== 1'b1) $display("FAIL frame_trigger: got %b want 1", trig); else passed++;
    start = 1'b0;
    gi = 0;
    read_block("frame_b0");
    read_block("frame_b1");
    read_block("frame_b2");
    total++;
    if (done !== 1'b1) $display("FAIL frame_done: got %b want 1", done); else passed++;
    for (int i = 0; i < 12; i++) begin
      exp_d = i < FW ? 32'(i + 1) : 32'd0;
      total++;
      if (got[i] !== exp_d) $display("FAIL frame_data[%0d]: got %0d want %0d", i, got[i], exp_d); else passed++;
    end
    tick(); tick();
    total++;
    if (rd_cnt - rd0 !== 10) $display("FAIL frame_rd_en: got %0d want 10", rd_cnt - rd0); else passed++;
    total++;
    if (trig_cnt - tr0 !== 1) $display("FAIL frame_trig_count: got %0d want 1", trig_cnt - tr0); else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL frame_done_count: got %0d want 1", done_cnt); else passed++;
    total++;
    if (frame_count !== 16'd1) $display("FAIL frame_count: got %0d want 1", frame_count); else passed++;
    total++;
    if (dut.state_q !== S_IDLE) $display("FAIL frame_end_state: got %0d want 0", dut.state_q); else passed++;
  endtask
  task automatic test_spurious();
    int rd0;
    rd0 = rd_cnt;
    pipe_read = 1'b1;
    tick();
    pipe_read = 1'b0;
    tick();
    total++;
    if (spur !== 1'b1) $display("FAIL spurious_flag: got %b want 1", spur); else passed++;
    total++;
    if (rd_cnt !== rd0) $display("FAIL spurious_rd_en: got %0d want %0d", rd_cnt, rd0); else passed++;
    total++;
    if (dut.state_q !== S_IDLE) $display("FAIL spurious_state: got %0d want 0", dut.state_q); else passed++;
  endtask
  task automatic test_threshold();
    force_cnt = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    total++;
    if (ready !== 1'b0) $display("FAIL thresh_below: got %b want 0", ready); else passed++;
    force_cnt = 4;
    tick();
    total++;
    if (ready !== 1'b1) $display("FAIL thresh_at: got %b want 1", ready); else passed++;
  endtask
  task automatic test_underflow();
    total++;
    if (under !== 1'b0) $display("FAIL underflow_pre: got %b want 0", under); else passed++;
    pipe_read = 1'b1;
    tick();
    total++;
    if (under !== 1'b1) $display("FAIL underflow_set: got %b want 1", under); else passed++;
    tick(); tick(); tick();
    pipe_read = 1'b0;
    total++;
    if (dut.state_q !== S_WAIT) $display("FAIL underflow_state: got %0d want 2", dut.state_q); else passed++;
    total++;
    if (dut.frame_rem_q !== CW'(6)) $display("FAIL underflow_rem: got %0d want 6", dut.frame_rem_q); else passed++;
  endtask
  task automatic test_reset_mid();
    for (int k = 0; k < 50 && !ready; k++) tick();
    total++;
    if (ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", ready); else passed++;
    pipe_read = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (dut.state_q !== S_IDLE) $display("FAIL midrst_state: got %0d want 0", dut.state_q); else passed++;
    total++;
    if ({trig, ready, done, under, spur, rd_en} !== 6'b0 || pipe_data !== 32'd0 || frame_count !== 16'd0) $display("FAIL midrst_outputs: got %b/%h/%0d want 0", {trig, ready, done, under, spur, rd_en}, pipe_data, frame_count); else passed++;
    total++;
    if (dut.blk_cnt_q !== '0 || dut.frame_rem_q !== '0) $display("FAIL midrst_counters: got blk %0d rem %0d want 0", dut.blk_cnt_q, dut.frame_rem_q); else passed++;
    rst = 1'b0;
    pipe_read = 1'b0;
    force_cnt = -1;
    tick();
  endtask
  task automatic test_continuous();
    int tr0;
    preload(1, 2 * FW);
    tr0 = trig_cnt;
    cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    gi = 0;
    read_block("cont_f0b0");
    read_block("cont_f0b1");
    read_block("cont_f0b2");
    total++;
    if (done !== 1'b1) $display("FAIL cont_done1: got %b want 1", done); else passed++;
    tick();
    total++;
    if (trig !== 1'b1) $display("FAIL cont_retrigger: got %b want 1", trig); else passed++;
    cont = 1'b0;
    gi = 0;
    read_block("cont_f1b0");
    read_block("cont_f1b1");
    read_block("cont_f1b2");
    total++;
    if (got[0] !== 32'd11 || got[9] !== 32'd20 || got[11] !== 32'd0) $display("FAIL cont_data2: got %0d,%0d,%0d want 11,20,0", got[0], got[9], got[11]); else passed++;
    tick(); tick();
    total++;
    if (frame_count !== 16'd2) $display("FAIL cont_count: got %0d want 2", frame_count); else passed++;
    total++;
    if (trig_cnt - tr0 !== 2 || dut.state_q !== S_IDLE) $display("FAIL cont_end: got trig %0d state %0d want 2/0", trig_cnt - tr0, dut.state_q); else passed++;
  endtask
  initial begin
    test_reset();
    test_frame();
    test_spurious();
    test_threshold();
    test_underflow();
    test_reset_mid();
    test_continuous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
